// File: rtl/vga_sdram_write_engine.sv
// Display write engine: turns 32-bit display write commands into 16-bit SDRAM
// write transfers, including a hardware fill loop that clears the framebuffer.
module vga_sdram_write_engine #(
  parameter logic [31:0] P_FB_BASE    = 32'h0000_0000,
  parameter int          P_H          = 640,
  parameter int          P_V          = 480,
  parameter logic [31:0] P_PIX_OFFSET = 32'h40
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iWR_REQ,
  output logic        oWR_BUSY,
  input  logic [31:0] iWR_ADDR,
  input  logic [31:0] iWR_DATA,
  output logic        oMEM_VALID,
  output logic [1:0]  oMEM_BYTEENA,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_ADDR,
  output logic [15:0] oMEM_DATA,
  input  logic        iMEM_BUSY,
  output logic        oCLEAR_ACTIVE
);

  localparam logic [31:0] LP_PIXELS = 32'(P_H * P_V);
  localparam logic [18:0] LP_LAST   = 19'(P_H * P_V - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PIXEL = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [18:0] r_count;
  logic [11:0] r_colour;

  logic        w_accept;
  logic        w_isClear;
  logic        w_isPixel;
  logic [31:0] w_offset;
  logic        w_valid;
  logic        w_unusedData;

  assign w_unusedData = &{1'b0, iWR_DATA[31:12]};

  assign w_accept  = iWR_REQ && (r_state == S_IDLE);
  assign w_offset  = iWR_ADDR - P_PIX_OFFSET;
  assign w_isClear = (iWR_ADDR == 32'd0);
  // The subtraction-based bound check cannot overflow for addresses near 2^32.
  assign w_isPixel = (iWR_ADDR >= P_PIX_OFFSET) && (w_offset < LP_PIXELS);
  assign w_valid   = (r_state != S_IDLE);

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_isClear) begin
          w_nextState = S_CLEAR;
        end else if (w_accept && w_isPixel) begin
          w_nextState = S_PIXEL;
        end
      end
      S_PIXEL: begin
        if (!iMEM_BUSY) begin
          w_nextState = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (!iMEM_BUSY && (r_count == LP_LAST)) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // r_count holds the pixel index for a single write and the fill position during a clear.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_count  <= 19'd0;
      r_colour <= 12'd0;
    end else if (w_accept) begin
      r_colour <= iWR_DATA[11:0];
      r_count  <= w_isPixel ? w_offset[18:0] : 19'd0;
    end else if ((r_state == S_CLEAR) && !iMEM_BUSY && (r_count != LP_LAST)) begin
      r_count <= r_count + 19'd1;
    end
  end

  assign oWR_BUSY      = w_valid;
  assign oMEM_VALID    = w_valid;
  assign oMEM_BYTEENA  = w_valid ? 2'b11 : 2'b00;
  assign oMEM_RW       = w_valid;
  assign oMEM_ADDR     = w_valid ? (P_FB_BASE + {13'd0, r_count}) : 32'd0;
  assign oMEM_DATA     = w_valid ? {4'h0, r_colour} : 16'd0;
  assign oCLEAR_ACTIVE = (r_state == S_CLEAR);

endmodule

// File: tb/tb_vga_sdram_write_engine.sv
// Directed bench for vga_sdram_write_engine: a full-size instance for pixel, drop
// and busy cases and a 4x2 instance so the clear fill stays short.
module tb_vga_sdram_write_engine;

  logic        clock;
  logic        reset;
  logic        reqFull;
  logic        reqSmall;
  logic [31:0] wrAddr;
  logic [31:0] wrData;
  logic        memBusy;

  logic        busyFull, validFull, rwFull, clearFull;
  logic [1:0]  byteEnaFull;
  logic [31:0] addrFull;
  logic [15:0] dataFull;

  logic        busySmall, validSmall, rwSmall, clearSmall;
  logic [1:0]  byteEnaSmall;
  logic [31:0] addrSmall;
  logic [15:0] dataSmall;

  int assertCount;
  int failCount;

  vga_sdram_write_engine dutFull (
    .iCLOCK(clock), .iRESET(reset), .iWR_REQ(reqFull), .oWR_BUSY(busyFull),
    .iWR_ADDR(wrAddr), .iWR_DATA(wrData), .oMEM_VALID(validFull),
    .oMEM_BYTEENA(byteEnaFull), .oMEM_RW(rwFull), .oMEM_ADDR(addrFull),
    .oMEM_DATA(dataFull), .iMEM_BUSY(memBusy), .oCLEAR_ACTIVE(clearFull)
  );

  vga_sdram_write_engine #(.P_H(4), .P_V(2)) dutSmall (
    .iCLOCK(clock), .iRESET(reset), .iWR_REQ(reqSmall), .oWR_BUSY(busySmall),
    .iWR_ADDR(wrAddr), .iWR_DATA(wrData), .oMEM_VALID(validSmall),
    .oMEM_BYTEENA(byteEnaSmall), .oMEM_RW(rwSmall), .oMEM_ADDR(addrSmall),
    .oMEM_DATA(dataSmall), .iMEM_BUSY(memBusy), .oCLEAR_ACTIVE(clearSmall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one command to the selected instance at a falling edge.
  task automatic applyStimulus(input logic toSmall, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    wrAddr = addr;
    wrData = data;
    if (toSmall) reqSmall = 1'b1;
    else         reqFull  = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stall;
    assertCount = 0;
    failCount   = 0;
    reset    = 1'b1;
    reqFull  = 1'b0;
    reqSmall = 1'b0;
    wrAddr   = 32'd0;
    wrData   = 32'd0;
    memBusy  = 1'b0;

    #2;
    checkOutput("rst_valid",   {31'd0, validFull},   32'd0);
    checkOutput("rst_busy",    {31'd0, busyFull},    32'd0);
    checkOutput("rst_byteena", {30'd0, byteEnaFull}, 32'd0);
    checkOutput("rst_rw",      {31'd0, rwFull},      32'd0);
    checkOutput("rst_addr",    addrFull,             32'd0);
    checkOutput("rst_data",    {16'd0, dataFull},    32'd0);
    checkOutput("rst_clear",   {31'd0, clearSmall},  32'd0);
    @(negedge clock);
    reset = 1'b0;

    // T1: single pixel write
    applyStimulus(1'b0, 32'h40 + 32'd641, 32'hFFFF_FF0A);
    @(negedge clock);
    reqFull = 1'b0;
    checkOutput("t1_valid",   {31'd0, validFull},   32'd1);
    checkOutput("t1_busy",    {31'd0, busyFull},    32'd1);
    checkOutput("t1_addr",    addrFull,             32'd641);
    checkOutput("t1_data",    {16'd0, dataFull},    32'h0F0A);
    checkOutput("t1_byteena", {30'd0, byteEnaFull}, 32'd3);
    checkOutput("t1_rw",      {31'd0, rwFull},      32'd1);
    checkOutput("t1_clear",   {31'd0, clearFull},   32'd0);
    @(negedge clock);
    checkOutput("t1_valid_n2", {31'd0, validFull}, 32'd0);
    checkOutput("t1_busy_n2",  {31'd0, busyFull},  32'd0);

    // T2: clear on the 4x2 instance with a 3-cycle stall on the third beat
    applyStimulus(1'b1, 32'd0, 32'h0000_0123);
    stall = 0;
    for (int beat = 0; beat < 8; ) begin
      @(negedge clock);
      reqSmall = 1'b0;
      checkOutput($sformatf("t2_valid_%0d", beat), {31'd0, validSmall}, 32'd1);
      checkOutput($sformatf("t2_addr_%0d", beat),  addrSmall,           beat);
      checkOutput($sformatf("t2_data_%0d", beat),  {16'd0, dataSmall},  32'h0123);
      checkOutput($sformatf("t2_clear_%0d", beat), {31'd0, clearSmall}, 32'd1);
      if (beat == 2 && stall < 3) begin
        memBusy = 1'b1;
        stall++;
      end else begin
        memBusy = 1'b0;
        beat++;
      end
    end
    @(negedge clock);
    checkOutput("t2_valid_end", {31'd0, validSmall}, 32'd0);
    checkOutput("t2_clear_end", {31'd0, clearSmall}, 32'd0);
    checkOutput("t2_busy_end",  {31'd0, busySmall},  32'd0);

    // T3: out-of-range addresses are accepted and dropped
    applyStimulus(1'b0, 32'h3F, 32'h0000_0FFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      reqFull = 1'b0;
      checkOutput($sformatf("t3a_valid_%0d", i), {31'd0, validFull}, 32'd0);
      checkOutput($sformatf("t3a_busy_%0d", i),  {31'd0, busyFull},  32'd0);
    end
    applyStimulus(1'b0, 32'h40 + 32'd307200, 32'h0000_0FFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      reqFull = 1'b0;
      checkOutput($sformatf("t3b_valid_%0d", i), {31'd0, validFull}, 32'd0);
      checkOutput($sformatf("t3b_busy_%0d", i),  {31'd0, busyFull},  32'd0);
    end

    // T4: second command held while the first is stalled by the memory
    memBusy = 1'b1;
    applyStimulus(1'b0, 32'h40 + 32'd5, 32'h0000_0ABC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      wrAddr = 32'h40 + 32'd6;
      wrData = 32'h0000_0123;
      checkOutput($sformatf("t4_valid1_%0d", i), {31'd0, validFull}, 32'd1);
      checkOutput($sformatf("t4_addr1_%0d", i),  addrFull,           32'd5);
      checkOutput($sformatf("t4_data1_%0d", i),  {16'd0, dataFull},  32'h0ABC);
    end
    memBusy = 1'b0;
    @(negedge clock);
    checkOutput("t4_gap_valid", {31'd0, validFull}, 32'd0);
    checkOutput("t4_gap_busy",  {31'd0, busyFull},  32'd0);
    @(negedge clock);
    reqFull = 1'b0;
    checkOutput("t4_valid2", {31'd0, validFull}, 32'd1);
    checkOutput("t4_addr2",  addrFull,           32'd6);
    checkOutput("t4_data2",  {16'd0, dataFull},  32'h0123);
    @(negedge clock);
    checkOutput("t4_valid_end", {31'd0, validFull}, 32'd0);

    // T5: asynchronous reset in the middle of a clear
    applyStimulus(1'b1, 32'd0, 32'h0000_0456);
    for (int beat = 0; beat < 3; beat++) begin
      @(negedge clock);
      reqSmall = 1'b0;
      checkOutput($sformatf("t5_addr_%0d", beat), addrSmall, beat);
    end
    @(negedge clock);
    checkOutput("t5_addr_3", addrSmall, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_valid",   {31'd0, validSmall},   32'd0);
    checkOutput("t5_rst_busy",    {31'd0, busySmall},    32'd0);
    checkOutput("t5_rst_clear",   {31'd0, clearSmall},   32'd0);
    checkOutput("t5_rst_addr",    addrSmall,             32'd0);
    checkOutput("t5_rst_data",    {16'd0, dataSmall},    32'd0);
    checkOutput("t5_rst_byteena", {30'd0, byteEnaSmall}, 32'd0);
    checkOutput("t5_rst_rw",      {31'd0, rwSmall},      32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h40 + 32'd10, 32'h0000_05A5);
    @(negedge clock);
    reqFull = 1'b0;
    checkOutput("t5_small_idle", {31'd0, validSmall}, 32'd0);
    checkOutput("t5_pix_valid",  {31'd0, validFull},  32'd1);
    checkOutput("t5_pix_addr",   addrFull,            32'd10);
    checkOutput("t5_pix_data",   {16'd0, dataFull},   32'h05A5);
    @(negedge clock);
    checkOutput("t5_pix_end",    {31'd0, validFull},  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
